calc_seq_ctrl: RTL and testbench

//  Parametrised signed keypad-calculator sequencer; replaces the fixed 16-bit controller.
//  - Accumulates decimal digits into two signed operands. Digit step: acc = acc*10 + d,

---
 rtl/calc_pkg.sv | 29 ++
 rtl/calc_mul_seq.sv | 82 ++++++++
 rtl/calc_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | calc_pkg: shared types and constants for the keypad calculator sequencer |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
package calc_pkg;

  localparam int RADIX = 10;

  typedef enum logic [2:0] {
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [2:0] {
    S_OP1      = 3'd0,
    S_OP2      = 3'd1,
    S_EXEC_AS  = 3'd2,
    S_EXEC_MUL = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  function automatic logic is_valid_op(input logic [2:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_mul_seq.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | calc_mul_seq: signed shift-add multiplier, one multiplier bit per cycle  |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module calc_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int               c_idx_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(WIDTH - 1);
  localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

  logic                 r_busy;
  logic                 r_done;
  logic [c_idx_w-1:0]   r_idx;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;

  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_term;

  assign w_a_ext = {{WIDTH{a[WIDTH-1]}}, a};

  // The multiplier's sign bit carries weight -2^(WIDTH-1), so its term is subtracted.
  always_comb begin
    w_term = '0;
    if (r_mplier[0]) begin
      w_term = (r_idx == c_last) ? -r_mcand : r_mcand;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_idx    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (abort) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (start && !r_busy) begin
      // Bit 0 is folded into the load so the product is ready after WIDTH edges.
      r_acc    <= b[0] ? w_a_ext : '0;
      r_mcand  <= w_a_ext << 1;
      r_mplier <= b >> 1;
      r_idx    <= c_idx_one;
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= r_acc + w_term;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_idx == c_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_idx  <= r_idx + c_idx_one;
        r_done <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done    = r_done;
  assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | calc_seq_ctrl: signed keypad-calculator sequencer (entry, exec, chain)   |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic             neg_valid,
  input  logic             eq_valid,
  input  logic             clr,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             entry_err
);

  localparam int c_mag_w = WIDTH - 1;
  localparam int c_acc_w = WIDTH + 3;
  localparam int c_cnt_w = $clog2(MAX_DIGITS + 1);
  localparam logic [c_acc_w-1:0] c_max_mag = {4'b0000, {c_mag_w{1'b1}}};
  localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_DIGITS);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  state_e               r_state;
  op_e                  r_op;
  logic [c_mag_w-1:0]   r_op1_mag;
  logic                 r_op1_neg;
  logic [c_cnt_w-1:0]   r_op1_cnt;
  logic [c_mag_w-1:0]   r_op2_mag;
  logic                 r_op2_neg;
  logic [c_cnt_w-1:0]   r_op2_cnt;
  logic                 r_mul_start;

  logic                 w_dig;
  logic                 w_op_ok;
  logic [c_mag_w-1:0]   w_cur_mag;
  logic [c_cnt_w-1:0]   w_cur_cnt;
  logic [c_acc_w-1:0]   w_cur_ext;
  logic [c_acc_w-1:0]   w_next_mag;
  logic                 w_digit_fits;
  logic [WIDTH-1:0]     w_op1_tc;
  logic [WIDTH-1:0]     w_op2_tc;
  logic [WIDTH:0]       w_ext1;
  logic [WIDTH:0]       w_ext2;
  logic [WIDTH:0]       w_sum;
  logic                 w_as_ovf;
  logic [2*WIDTH-1:0]   w_prod;
  logic                 w_mul_done;
  logic                 w_mul_ovf;
  logic [WIDTH-1:0]     w_res_abs;
  logic                 w_res_min;

  assign w_dig   = digit_valid && ({1'b0, digit} < 5'(RADIX));
  assign w_op_ok = op_valid && is_valid_op(op);

  // Digit step: acc*10 + d as acc*8 + acc*2 + d, checked against the largest magnitude.
  assign w_cur_mag    = (r_state == S_OP2) ? r_op2_mag : r_op1_mag;
  assign w_cur_cnt    = (r_state == S_OP2) ? r_op2_cnt : r_op1_cnt;
  assign w_cur_ext    = {4'b0000, w_cur_mag};
  assign w_next_mag   = (w_cur_ext << 3) + (w_cur_ext << 1) + {{(c_acc_w-4){1'b0}}, digit};
  assign w_digit_fits = (w_cur_cnt < c_max_cnt) && (w_next_mag <= c_max_mag);

  assign w_op1_tc = r_op1_neg ? -{1'b0, r_op1_mag} : {1'b0, r_op1_mag};
  assign w_op2_tc = r_op2_neg ? -{1'b0, r_op2_mag} : {1'b0, r_op2_mag};
  assign w_ext1   = {w_op1_tc[WIDTH-1], w_op1_tc};
  assign w_ext2   = {w_op2_tc[WIDTH-1], w_op2_tc};
  assign w_sum    = (r_op == OP_SUB) ? (w_ext1 - w_ext2) : (w_ext1 + w_ext2);
  assign w_as_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

  assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

  // Only -2^(WIDTH-1) keeps its MSB after taking the absolute value.
  assign w_res_abs = result[WIDTH-1] ? -result : result;
  assign w_res_min = w_res_abs[WIDTH-1];

  calc_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .nRST    (nRST),
    .start   (r_mul_start),
    .abort   (clr),
    .a       (w_op1_tc),
    .b       (w_op2_tc),
    .done    (w_mul_done),
    .product (w_prod)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_OP1;
      r_op         <= OP_ADD;
      r_op1_mag    <= '0;
      r_op1_neg    <= 1'b0;
      r_op1_cnt    <= '0;
      r_op2_mag    <= '0;
      r_op2_neg    <= 1'b0;
      r_op2_cnt    <= '0;
      r_mul_start  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      overflow     <= 1'b0;
      entry_err    <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      if (clr) begin
        r_state      <= S_OP1;
        r_op         <= OP_ADD;
        r_op1_mag    <= '0;
        r_op1_neg    <= 1'b0;
        r_op1_cnt    <= '0;
        r_op2_mag    <= '0;
        r_op2_neg    <= 1'b0;
        r_op2_cnt    <= '0;
        busy         <= 1'b0;
        result_valid <= 1'b0;
        result       <= '0;
        overflow     <= 1'b0;
        entry_err    <= 1'b0;
      end else begin
        case (r_state)
          S_OP1: begin
            if (!eq_valid) begin
              if (w_op_ok) begin
                r_op    <= op_e'(op);
                r_state <= S_OP2;
              end else if (neg_valid) begin
                r_op1_neg <= ~r_op1_neg;
              end else if (w_dig) begin
                if (w_digit_fits) begin
                  r_op1_mag <= w_next_mag[c_mag_w-1:0];
                  r_op1_cnt <= r_op1_cnt + c_cnt_one;
                  entry_err <= 1'b0;
                end else begin
                  entry_err <= 1'b1;
                end
              end
            end
          end
          S_OP2: begin
            if (eq_valid) begin
              r_state     <= (r_op == OP_MUL) ? S_EXEC_MUL : S_EXEC_AS;
              r_mul_start <= (r_op == OP_MUL);
              busy        <= 1'b1;
            end else if (w_op_ok) begin
              r_op <= op_e'(op);
            end else if (neg_valid) begin
              r_op2_neg <= ~r_op2_neg;
            end else if (w_dig) begin
              if (w_digit_fits) begin
                r_op2_mag <= w_next_mag[c_mag_w-1:0];
                r_op2_cnt <= r_op2_cnt + c_cnt_one;
                entry_err <= 1'b0;
              end else begin
                entry_err <= 1'b1;
              end
            end
          end
          S_EXEC_AS: begin
            result       <= w_sum[WIDTH-1:0];
            overflow     <= w_as_ovf;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            r_state      <= S_DONE;
          end
          S_EXEC_MUL: begin
            if (w_mul_done) begin
              result       <= w_prod[WIDTH-1:0];
              overflow     <= w_mul_ovf;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              r_state      <= S_DONE;
            end
          end
          S_DONE: begin
            if (eq_valid || w_op_ok || neg_valid) begin
              result_valid <= 1'b0;
              if (w_res_min) begin
                r_op1_mag <= '0;
                r_op1_neg <= 1'b0;
                r_op1_cnt <= '0;
                r_op2_mag <= '0;
                r_op2_neg <= 1'b0;
                r_op2_cnt <= '0;
                entry_err <= 1'b1;
                r_state   <= S_OP1;
              end else begin
                r_op1_mag <= w_res_abs[c_mag_w-1:0];
                r_op1_cnt <= '0;
                if (eq_valid) begin
                  // Repeat-equals keeps op2 and the latched operation.
                  r_op1_neg   <= result[WIDTH-1];
                  r_state     <= (r_op == OP_MUL) ? S_EXEC_MUL : S_EXEC_AS;
                  r_mul_start <= (r_op == OP_MUL);
                  busy        <= 1'b1;
                end else if (w_op_ok) begin
                  r_op1_neg <= result[WIDTH-1];
                  r_op2_mag <= '0;
                  r_op2_neg <= 1'b0;
                  r_op2_cnt <= '0;
                  r_op      <= op_e'(op);
                  r_state   <= S_OP2;
                end else begin
                  r_op1_neg <= ~result[WIDTH-1];
                  r_op2_mag <= '0;
                  r_op2_neg <= 1'b0;
                  r_op2_cnt <= '0;
                  r_state   <= S_OP1;
                end
              end
            end else if (w_dig) begin
              r_op1_mag    <= {{(c_mag_w-4){1'b0}}, digit};
              r_op1_neg    <= 1'b0;
              r_op1_cnt    <= c_cnt_one;
              r_op2_mag    <= '0;
              r_op2_neg    <= 1'b0;
              r_op2_cnt    <= '0;
              entry_err    <= 1'b0;
              result_valid <= 1'b0;
              r_state      <= S_OP1;
            end
          end
          default: begin
            r_state <= S_OP1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_calc_seq_ctrl: scoreboard bench for the calculator sequencer          |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         nRST = 1'b0;
  logic         digit_valid = 1'b0;
  logic [3:0]   digit = 4'd0;
  logic         op_valid = 1'b0;
  logic [2:0]   op = 3'd0;
  logic         neg_valid = 1'b0;
  logic         eq_valid = 1'b0;
  logic         clr = 1'b0;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result;
  logic         overflow;
  logic         entry_err;

  int    checks = 0;
  int    failures = 0;
  string cur_test = "init";

  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
  } exp_t;
  exp_t exp_q[$];

  calc_seq_ctrl #(.WIDTH(W), .MAX_DIGITS(5)) dut (
    .clk          (clk),
    .nRST         (nRST),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .op_valid     (op_valid),
    .op           (op),
    .neg_valid    (neg_valid),
    .eq_valid     (eq_valid),
    .clr          (clr),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .overflow     (overflow),
    .entry_err    (entry_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%s]: got %0h expected %0h", name, cur_test, act, exp);
    end
  endtask

  // Monitor: every rising result_valid consumes one expected entry.
  initial begin : monitor
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && prev_rv !== 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result [%s]: got %0h expected none", cur_test, result);
        end else begin
          e = exp_q.pop_front();
          check("result", {16'h0, result}, {16'h0, e.res});
          check("overflow", {31'h0, overflow}, {31'h0, e.ovf});
        end
      end
      prev_rv = result_valid;
    end
  end

  task automatic press_digit(input int d);
    @(negedge clk); digit = 4'(d); digit_valid = 1'b1;
    @(negedge clk); digit_valid = 1'b0;
  endtask

  task automatic enter_num(input int n);
    int ds[$];
    int v;
    v = n;
    if (v == 0) ds.push_front(0);
    while (v > 0) begin
      ds.push_front(v % 10);
      v = v / 10;
    end
    foreach (ds[i]) press_digit(ds[i]);
  endtask

  task automatic press_op(input logic [2:0] c);
    @(negedge clk); op = c; op_valid = 1'b1;
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic press_neg();
    @(negedge clk); neg_valid = 1'b1;
    @(negedge clk); neg_valid = 1'b0;
  endtask

  // Latency counts cycles from the eq_valid cycle to the first result_valid cycle.
  task automatic calc(input logic [W-1:0] r, input logic ov, input int exp_lat, input int exp_busy);
    int lat;
    int bcnt;
    exp_q.push_back('{res: r, ovf: ov});
    @(negedge clk); eq_valid = 1'b1;
    @(negedge clk); eq_valid = 1'b0;
    lat  = 1;
    bcnt = busy ? 1 : 0;
    while (result_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", bcnt, exp_busy);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog [%s]: got timeout expected completion", cur_test);
    $fatal(1);
  end

  initial begin : stim
    cur_test = "reset";
    repeat (3) @(negedge clk);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_valid", {31'h0, result_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ovf", {31'h0, overflow}, 32'h0);
    check("rst_err", {31'h0, entry_err}, 32'h0);
    nRST = 1'b1;

    cur_test = "add_12_34";
    enter_num(12); press_op(OP_ADD); enter_num(34);
    calc(16'd46, 1'b0, 2, 1);

    cur_test = "mul_neg7_6";
    press_digit(7); press_neg(); press_op(OP_MUL); press_digit(6);
    calc(16'hFFD6, 1'b0, W + 2, W + 1);

    cur_test = "digit_limit";
    enter_num(32767);
    check("err_before", {31'h0, entry_err}, 32'h0);
    press_digit(8);
    check("err_reject", {31'h0, entry_err}, 32'h1);
    press_op(OP_ADD); press_digit(1);
    check("err_cleared", {31'h0, entry_err}, 32'h0);
    calc(16'h8000, 1'b1, 2, 1);

    cur_test = "chain_refused";
    press_op(OP_ADD);
    check("refuse_err", {31'h0, entry_err}, 32'h1);
    check("refuse_valid", {31'h0, result_valid}, 32'h0);
    check("refuse_busy", {31'h0, busy}, 32'h0);

    cur_test = "repeat_eq";
    press_digit(5); press_op(OP_SUB); press_digit(9);
    calc(16'hFFFC, 1'b0, 2, 1);
    calc(16'hFFF3, 1'b0, 2, 1);
    press_op(OP_ADD); press_digit(2);
    calc(16'hFFF5, 1'b0, 2, 1);

    cur_test = "sub_ovf";
    enter_num(32767); press_neg(); press_op(OP_SUB); press_digit(2);
    calc(16'h7FFF, 1'b1, 2, 1);

    cur_test = "mul_ovf";
    enter_num(300); press_op(OP_MUL); enter_num(200);
    calc(16'hEA60, 1'b1, W + 2, W + 1);

    cur_test = "clr_mid_mul";
    enter_num(255); press_op(OP_MUL); enter_num(255);
    @(negedge clk); eq_valid = 1'b1;
    @(negedge clk); eq_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("clr_busy_before", {31'h0, busy}, 32'h1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("clr_busy", {31'h0, busy}, 32'h0);
    check("clr_result", {16'h0, result}, 32'h0);
    check("clr_valid", {31'h0, result_valid}, 32'h0);
    check("clr_ovf", {31'h0, overflow}, 32'h0);
    press_digit(3); press_op(OP_MUL); press_digit(4);
    calc(16'd12, 1'b0, W + 2, W + 1);

    cur_test = "nrst_mid_mul";
    press_digit(2); press_op(OP_MUL); press_digit(3);
    @(negedge clk); eq_valid = 1'b1;
    @(negedge clk); eq_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("nrst_busy_before", {31'h0, busy}, 32'h1);
    nRST = 1'b0;
    #1;
    check("nrst_busy", {31'h0, busy}, 32'h0);
    check("nrst_result", {16'h0, result}, 32'h0);
    check("nrst_valid", {31'h0, result_valid}, 32'h0);
    @(negedge clk); nRST = 1'b1;
    press_digit(1); press_op(OP_ADD); press_digit(1);
    calc(16'd2, 1'b0, 2, 1);

    cur_test = "drain";
    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
